rob_multi: RTL and testbench

Parametrised reorder buffer that replaces the single-commit ROB between the decoder, the reservation station, the load/store buffer and the register file. It tracks DEPTH in-flight instructions in program order and accepts results on NUM_WB writeback ports. It retires up to two instructions per cycle and resolves branch mispredictions with a registered flush/redirect. Unlike the previous generation, it uses every entry (count-based full/empty) and reports its occupancy.

---
 rtl/rob_pkg.sv | 20 ++
 rtl/rob_search_mux.sv | 38 +++
 rtl/rob_multi.sv | 216 +++++++++++++++++++++
 tb/tb_rob_multi.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Encodings shared by the reorder buffer and its bench: instruction types,
// per-entry status and the default depth.
package rob_pkg;
  localparam int ROB_DEPTH = 16;

  localparam logic [1:0] BR   = 2'd0;
  localparam logic [1:0] ST   = 2'd1;
  localparam logic [1:0] JALR = 2'd2;
  localparam logic [1:0] RG   = 2'd3;

  // status      | meaning
  // STAT_FREE   | slot unused
  // STAT_ISSUED | allocated, waiting for its result
  // STAT_DONE   | result present, eligible to retire at head
  typedef enum logic [1:0] {
    STAT_FREE   = 2'd0,
    STAT_ISSUED = 2'd1,
    STAT_DONE   = 2'd2
  } rob_stat_e;
endpackage

// File: rtl/rob_search_mux.sv
// Operand lookup for one search port: commit-register bypass first, then
// same-cycle writeback, then the stored result of a DONE entry.
module rob_search_mux #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int NUM_WB   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic [IDX_W-1:0]          search_id,
  input  logic [COMMIT_W-1:0]       commit_valid,
  input  logic [COMMIT_W*IDX_W-1:0] commit_rob_id,
  input  logic [COMMIT_W*32-1:0]    commit_val,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]   wb_rob_id,
  input  logic [NUM_WB*32-1:0]      wb_value,
  input  logic [DEPTH-1:0]          entry_done,
  input  logic [DEPTH*32-1:0]       entry_val,
  output logic                      ready,
  output logic [31:0]               val
);
  always_comb begin
    ready = entry_done[search_id];
    val   = entry_done[search_id] ? entry_val[int'(search_id)*32 +: 32] : 32'h0;
    // Later loop iterations override earlier ones, so higher indices win.
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p] && wb_rob_id[p*IDX_W +: IDX_W] == search_id) begin
        ready = 1'b1;
        val   = wb_value[p*32 +: 32];
      end
    end
    for (int l = 0; l < COMMIT_W; l++) begin
      if (commit_valid[l] && commit_rob_id[l*IDX_W +: IDX_W] == search_id) begin
        ready = 1'b1;
        val   = commit_val[l*32 +: 32];
      end
    end
  end
endmodule

// File: rtl/rob_multi.sv
// Reorder buffer with count-based full/empty, NUM_WB writeback ports, up to
// two retirements per cycle and a registered flush/redirect on mispredicts.
module rob_multi
  import rob_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int IDX_W    = $clog2(DEPTH),
  parameter int NUM_WB   = 2,
  parameter int COMMIT_W = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      dec_ready,
  input  logic [1:0]                dec_type,
  input  logic [4:0]                dec_rd,
  input  logic [31:0]               dec_jaddr,
  output logic [IDX_W-1:0]          empty_rob_id,
  output logic                      rob_full,
  output logic [IDX_W:0]            rob_count,
  input  logic [NUM_WB-1:0]         wb_valid,
  input  logic [NUM_WB*IDX_W-1:0]   wb_rob_id,
  input  logic [NUM_WB*32-1:0]      wb_value,
  output logic                      store_enable,
  output logic [COMMIT_W-1:0]       commit_valid,
  output logic [COMMIT_W*IDX_W-1:0] commit_rob_id,
  output logic [COMMIT_W*5-1:0]     commit_reg_id,
  output logic [COMMIT_W*32-1:0]    commit_val,
  output logic                      melt,
  output logic                      flush,
  output logic [31:0]               redirect_pc,
  input  logic [IDX_W-1:0]          search_rob_id_1,
  input  logic [IDX_W-1:0]          search_rob_id_2,
  output logic                      search_ready_1,
  output logic                      search_ready_2,
  output logic [31:0]               search_val_1,
  output logic [31:0]               search_val_2
);
  typedef logic [IDX_W:0]   cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  rob_stat_e   stat_q  [DEPTH], stat_d  [DEPTH];
  logic [1:0]  type_q  [DEPTH], type_d  [DEPTH];
  logic [4:0]  rd_q    [DEPTH], rd_d    [DEPTH];
  logic [31:0] val_q   [DEPTH], val_d   [DEPTH];
  logic [31:0] jaddr_q [DEPTH], jaddr_d [DEPTH];
  idx_t        head_q, head_d, tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [COMMIT_W-1:0]       cvalid_q, cvalid_d;
  logic [COMMIT_W*IDX_W-1:0] crob_q, crob_d;
  logic [COMMIT_W*5-1:0]     creg_q, creg_d;
  logic [COMMIT_W*32-1:0]    cval_q, cval_d;
  logic        melt_q, melt_d, flush_q, flush_d;
  logic [31:0] redir_q, redir_d;

  idx_t head_p1;
  logic lane0, lane1, do_issue;
  logic [DEPTH-1:0]    entry_done;
  logic [DEPTH*32-1:0] entry_val;

  assign rob_full = (count_q == cnt_t'(DEPTH));
  assign head_p1  = head_q + idx_t'(1);
  assign do_issue = dec_ready && !rob_full;
  assign lane0    = (count_q != '0) && (stat_q[head_q] == STAT_DONE);
  // Lane 1 only pairs with a lane-0 retirement that cannot redirect the pipe.
  assign lane1    = (COMMIT_W == 2) && lane0 &&
                    (type_q[head_q] == RG || type_q[head_q] == ST) &&
                    (stat_q[head_p1] == STAT_DONE) && (head_p1 != tail_q) &&
                    (type_q[head_p1] == RG);

  always_comb begin
    stat_d   = stat_q;
    type_d   = type_q;
    rd_d     = rd_q;
    val_d    = val_q;
    jaddr_d  = jaddr_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cvalid_d = cvalid_q;
    crob_d   = crob_q;
    creg_d   = creg_q;
    cval_d   = cval_q;
    melt_d   = melt_q;
    flush_d  = flush_q;
    redir_d  = redir_q;
    if (rdy_in) begin
      if (flush_q) begin
        stat_d   = '{default: STAT_FREE};
        head_d   = '0;
        tail_d   = '0;
        count_d  = '0;
        cvalid_d = '0;
        melt_d   = 1'b0;
        flush_d  = 1'b0;
      end else begin
        cvalid_d = '0;
        melt_d   = 1'b0;
        flush_d  = 1'b0;
        for (int p = 0; p < NUM_WB; p++) begin
          if (wb_valid[p]) begin
            stat_d[wb_rob_id[p*IDX_W +: IDX_W]] = STAT_DONE;
            val_d[wb_rob_id[p*IDX_W +: IDX_W]]  = wb_value[p*32 +: 32];
          end
        end
        if (do_issue) begin
          stat_d[tail_q]  = STAT_ISSUED;
          type_d[tail_q]  = dec_type;
          rd_d[tail_q]    = dec_rd;
          jaddr_d[tail_q] = dec_jaddr;
          val_d[tail_q]   = 32'h0;
          tail_d          = tail_q + idx_t'(1);
        end
        if (lane0) begin
          stat_d[head_q]    = STAT_FREE;
          crob_d[IDX_W-1:0] = head_q;
          creg_d[4:0]       = rd_q[head_q];
          case (type_q[head_q])
            RG: begin
              cvalid_d[0]  = 1'b1;
              cval_d[31:0] = val_q[head_q];
            end
            JALR: begin
              cvalid_d[0]  = 1'b1;
              cval_d[31:0] = jaddr_q[head_q];
              melt_d       = 1'b1;
              redir_d      = val_q[head_q];
            end
            BR: begin
              if (val_q[head_q] != jaddr_q[head_q]) begin
                flush_d = 1'b1;
                redir_d = val_q[head_q];
              end
            end
            default: ;
          endcase
        end
        if (lane1) begin
          stat_d[head_p1]                         = STAT_FREE;
          cvalid_d[COMMIT_W-1]                    = 1'b1;
          crob_d[(COMMIT_W-1)*IDX_W +: IDX_W]     = head_p1;
          creg_d[(COMMIT_W-1)*5 +: 5]             = rd_q[head_p1];
          cval_d[(COMMIT_W-1)*32 +: 32]           = val_q[head_p1];
        end
        head_d  = head_q + idx_t'(lane0) + idx_t'(lane1);
        count_d = count_q + cnt_t'(do_issue) - cnt_t'(lane0) - cnt_t'(lane1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      stat_q   <= '{default: STAT_FREE};
      type_q   <= '{default: 2'd0};
      rd_q     <= '{default: 5'd0};
      val_q    <= '{default: 32'h0};
      jaddr_q  <= '{default: 32'h0};
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cvalid_q <= '0;
      crob_q   <= '0;
      creg_q   <= '0;
      cval_q   <= '0;
      melt_q   <= 1'b0;
      flush_q  <= 1'b0;
      redir_q  <= '0;
    end else begin
      stat_q   <= stat_d;
      type_q   <= type_d;
      rd_q     <= rd_d;
      val_q    <= val_d;
      jaddr_q  <= jaddr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cvalid_q <= cvalid_d;
      crob_q   <= crob_d;
      creg_q   <= creg_d;
      cval_q   <= cval_d;
      melt_q   <= melt_d;
      flush_q  <= flush_d;
      redir_q  <= redir_d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_done[i]          = (stat_q[i] == STAT_DONE);
      entry_val[i*32 +: 32]  = val_q[i];
    end
  end

  assign empty_rob_id  = tail_q;
  assign rob_count     = count_q;
  assign store_enable  = (count_q != '0) && (type_q[head_q] == ST);
  assign commit_valid  = cvalid_q;
  assign commit_rob_id = crob_q;
  assign commit_reg_id = creg_q;
  assign commit_val    = cval_q;
  assign melt          = melt_q;
  assign flush         = flush_q;
  assign redirect_pc   = redir_q;

  rob_search_mux #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) u_search_1 (
    .search_id(search_rob_id_1), .commit_valid(cvalid_q), .commit_rob_id(crob_q),
    .commit_val(cval_q), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .entry_done(entry_done), .entry_val(entry_val), .ready(search_ready_1), .val(search_val_1)
  );

  rob_search_mux #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)) u_search_2 (
    .search_id(search_rob_id_2), .commit_valid(cvalid_q), .commit_rob_id(crob_q),
    .commit_val(cval_q), .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .entry_done(entry_done), .entry_val(entry_val), .ready(search_ready_2), .val(search_val_2)
  );
endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: a DEPTH=16 instance for the main scenarios and
// a DEPTH=4 instance for the full/drop boundary.
module tb_rob_multi;
  import rob_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rdy, dec_ready, dec_ready4;
  logic [1:0]  dec_type;
  logic [4:0]  dec_rd;
  logic [31:0] dec_jaddr;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_rob_id;
  logic [63:0] wb_value;
  logic [3:0]  s_id1, s_id2;

  logic [3:0]  empty_id;
  logic        full, store_en, melt, flush, s_rdy1, s_rdy2;
  logic [4:0]  count;
  logic [1:0]  cvalid;
  logic [7:0]  crob;
  logic [9:0]  creg;
  logic [63:0] cval;
  logic [31:0] redir, s_val1, s_val2;

  logic [1:0]  empty4, cvalid4;
  logic        full4, store4, melt4, flush4, r41, r42;
  logic [2:0]  count4;
  logic [3:0]  crob4;
  logic [9:0]  creg4;
  logic [63:0] cval4;
  logic [31:0] redir4, v41, v42;

  rob_multi #(.DEPTH(16)) dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .dec_ready(dec_ready),
    .dec_type(dec_type), .dec_rd(dec_rd), .dec_jaddr(dec_jaddr),
    .empty_rob_id(empty_id), .rob_full(full), .rob_count(count),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .store_enable(store_en), .commit_valid(cvalid), .commit_rob_id(crob),
    .commit_reg_id(creg), .commit_val(cval), .melt(melt), .flush(flush),
    .redirect_pc(redir), .search_rob_id_1(s_id1), .search_rob_id_2(s_id2),
    .search_ready_1(s_rdy1), .search_ready_2(s_rdy2),
    .search_val_1(s_val1), .search_val_2(s_val2)
  );

  rob_multi #(.DEPTH(4)) u4 (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), .dec_ready(dec_ready4),
    .dec_type(dec_type), .dec_rd(dec_rd), .dec_jaddr(dec_jaddr),
    .empty_rob_id(empty4), .rob_full(full4), .rob_count(count4),
    .wb_valid(2'b00), .wb_rob_id(4'h0), .wb_value(64'h0),
    .store_enable(store4), .commit_valid(cvalid4), .commit_rob_id(crob4),
    .commit_reg_id(creg4), .commit_val(cval4), .melt(melt4), .flush(flush4),
    .redirect_pc(redir4), .search_rob_id_1(2'd0), .search_rob_id_2(2'd0),
    .search_ready_1(r41), .search_ready_2(r42),
    .search_val_1(v41), .search_val_2(v42)
  );

  int errors = 0;
  int checks = 0;
  int drops4 = 0;

  // Protocol monitor: issue requests presented while the small ROB is full.
  always @(posedge clk) if (rst_n && rdy && dec_ready4 && full4) drops4++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; dec_ready = 1'b0; dec_ready4 = 1'b0;
    dec_type = RG; dec_rd = '0; dec_jaddr = '0;
    wb_valid = '0; wb_rob_id = '0; wb_value = '0; s_id1 = '0; s_id2 = '0;
    #12;
    check("rst_count", 64'(count), 0);
    check("rst_full", 64'(full), 0);
    check("rst_cvalid", 64'(cvalid), 0);
    check("rst_flush_melt", {62'h0, flush, melt}, 0);
    check("rst_tail", 64'(empty_id), 0);
    rst_n = 1'b1;
    tick();

    // DEPTH=4 fill and drop
    dec_ready4 = 1'b1; dec_type = RG;
    repeat (4) tick();
    check("d4_full", 64'(full4), 1);
    check("d4_count", 64'(count4), 4);
    tick();
    check("d4_count_drop", 64'(count4), 4);
    check("d4_tail_drop", 64'(empty4), 0);
    check("d4_drop_seen", 64'(drops4), 1);
    dec_ready4 = 1'b0;

    // Two RG committed together
    dec_ready = 1'b1; dec_type = RG; dec_rd = 5'd5; s_id1 = 4'd0;
    tick();
    check("rg_tail1", 64'(empty_id), 1);
    check("srch_issued", 64'(s_rdy1), 0);
    dec_rd = 5'd6;
    tick();
    dec_ready = 1'b0;
    wb_valid = 2'b11; wb_rob_id = {4'd1, 4'd0}; wb_value = {32'h22, 32'h11};
    tick();
    wb_valid = 2'b00;
    #1;
    check("rg_count2", 64'(count), 2);
    check("srch_entry", {31'h0, s_rdy1, s_val1}, {32'h1, 32'h11});
    tick();
    check("dual_valid", 64'(cvalid), 2'b11);
    check("dual_val", cval, {32'h22, 32'h11});
    check("dual_rob", 64'(crob), 8'h10);
    check("dual_reg", 64'(creg), 10'hC5);
    check("dual_count", 64'(count), 0);
    s_id1 = 4'd1;
    #1;
    check("srch_commit", {31'h0, s_rdy1, s_val1}, {32'h1, 32'h22});
    tick();
    check("dual_clear", 64'(cvalid), 0);

    // Mispredicted BR flushes a younger RG; rdy low holds the flush
    dec_ready = 1'b1; dec_type = BR; dec_jaddr = 32'h100;
    tick();
    check("br_tail", 64'(empty_id), 3);
    dec_type = RG; dec_rd = 5'd7;
    wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd2}; wb_value = {32'h0, 32'h200};
    tick();
    dec_ready = 1'b0;
    wb_valid = 2'b10; wb_rob_id = {4'd3, 4'd0}; wb_value = {32'h33, 32'h0};
    tick();
    wb_valid = 2'b00;
    check("br_flush", 64'(flush), 1);
    check("br_redir", 64'(redir), 32'h200);
    check("br_cvalid", 64'(cvalid), 0);
    check("br_count", 64'(count), 1);
    rdy = 1'b0;
    tick();
    check("hold_flush", 64'(flush), 1);
    check("hold_count", 64'(count), 1);
    rdy = 1'b1;
    tick();
    check("fl_pulse_end", 64'(flush), 0);
    check("fl_count", 64'(count), 0);
    check("fl_tail", 64'(empty_id), 0);
    tick();
    check("fl_discard", 64'(cvalid), 0);

    // JALR retires alone; younger RG follows next cycle
    dec_ready = 1'b1; dec_type = JALR; dec_rd = 5'd1; dec_jaddr = 32'h84;
    tick();
    dec_type = RG; dec_rd = 5'd2;
    tick();
    dec_ready = 1'b0;
    wb_valid = 2'b11; wb_rob_id = {4'd1, 4'd0}; wb_value = {32'h55, 32'h400};
    tick();
    wb_valid = 2'b00; s_id2 = 4'd1;
    #1;
    check("srch2_entry", {31'h0, s_rdy2, s_val2}, {32'h1, 32'h55});
    tick();
    check("jalr_valid", 64'(cvalid), 2'b01);
    check("jalr_val", 64'(cval[31:0]), 32'h84);
    check("jalr_melt", 64'(melt), 1);
    check("jalr_redir", 64'(redir), 32'h400);
    check("jalr_reg", 64'(creg[4:0]), 1);
    tick();
    check("after_jalr", {cvalid, melt, crob[3:0], cval[31:0]}, {2'b01, 1'b0, 4'd1, 32'h55});
    tick();

    // Same-cycle writeback bypass, higher port wins
    wb_valid = 2'b11; wb_rob_id = {4'd3, 4'd3}; wb_value = {32'hABCD, 32'h1111};
    s_id1 = 4'd3; s_id2 = 4'd5;
    #1;
    check("byp_s1", {31'h0, s_rdy1, s_val1}, {32'h1, 32'hABCD});
    check("byp_s2_miss", 64'(s_rdy2), 0);
    wb_valid = 2'b00;
    #1;
    check("byp_gone", 64'(s_rdy1), 0);

    // Wrap-around from a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      dec_ready = 1'b1; dec_type = RG; dec_rd = 5'(i);
      tick();
      dec_ready = 1'b0;
      wb_valid = 2'b01; wb_rob_id = {4'd0, 4'(i % 16)}; wb_value = {32'h0, 32'h1000 + 32'(i)};
      tick();
      wb_valid = 2'b00;
      tick();
      check($sformatf("wrap_id%0d", i), {cvalid, crob[3:0]}, {2'b01, 4'(i % 16)});
      check($sformatf("wrap_val%0d", i), 64'(cval[31:0]), 32'h1000 + 32'(i));
    end

    // Asynchronous reset mid-stream
    dec_ready = 1'b1; dec_type = JALR; dec_rd = 5'd3; dec_jaddr = 32'h200;
    tick();
    dec_type = RG; dec_rd = 5'd4;
    wb_valid = 2'b01; wb_rob_id = {4'd0, 4'd4}; wb_value = {32'h0, 32'h300};
    tick();
    dec_ready = 1'b0; wb_valid = 2'b00;
    tick();
    check("pre_rst", {melt, count}, {1'b1, 5'd1});
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {melt, flush, cvalid, count, empty_id}, 0);
    check("arst_regs", {redir, cval[31:0]}, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
